// File: rtl/mem_access_unit.sv
// mem_access_unit: Avalon-MM load/store master with lane steering, load extension,
// misalignment detection and waitrequest timeout.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 255
) (
    input  logic                    clk,
    input  logic                    reset_i,
    input  logic                    req_i,
    input  logic                    req_we_i,
    input  logic [1:0]              req_size_i,
    input  logic                    req_signed_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    misalign_o,
    output logic                    timeout_o,
    output logic [ADDR_WIDTH-1:0]   address,
    output logic                    read,
    output logic                    write,
    input  logic                    waitrequest,
    output logic [DATA_WIDTH-1:0]   writedata,
    output logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic [DATA_WIDTH-1:0]   readdata
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFS   = $clog2(BYTES);
    localparam int CW    = MAX_WAIT > 0 ? $clog2(MAX_WAIT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_n;

    logic [CW-1:0]         cnt;
    logic [1:0]            size_q;
    logic                  signed_q;
    logic [OFS-1:0]        ofs_q, ofs;
    logic                  mis, tmo, sgn;
    int                    wn, rn;
    logic [DATA_WIDTH-1:0] keep, wdn, shifted, ext;
    logic [BYTES-1:0]      ben;

    assign ofs     = req_addr_i[OFS-1:0];
    assign shifted = readdata >> {ofs_q, 3'b000};

    always_comb begin
        wn   = 1 << req_size_i;
        rn   = 1 << size_q;
        keep = '0;
        ben  = '0;
        sgn  = 1'b0;
        ext  = '0;
        for (int i = 0; i < BYTES; i++) begin
            keep[8*i +: 8] = i < wn ? 8'hff : 8'h00;
            ben[i]         = i >= int'(ofs) && i < int'(ofs) + wn;
            if (i == rn - 1) sgn = shifted[8*i+7];
        end
        for (int i = 0; i < BYTES; i++)
            ext[8*i +: 8] = i < rn ? shifted[8*i +: 8] : {8{sgn & signed_q}};
        wdn = (req_wdata_i & keep) << {ofs, 3'b000};
        mis = (DATA_WIDTH == 32 && req_size_i == 2'd3) || (int'(ofs) % wn) != 0;
        // Timeout only while still stalled, so a same-cycle completion wins.
        tmo = MAX_WAIT > 0 && waitrequest && int'(cnt) == MAX_WAIT - 1;
        state_n = state == IDLE   ? (req_i ? (mis ? RESP : ACCESS) : IDLE) :
                  state == ACCESS ? ((!waitrequest || tmo) ? RESP : ACCESS) : IDLE;
    end

    always_ff @(posedge clk or posedge reset_i)
        if (reset_i) state <= IDLE;
        else state <= state_n;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            rdata_o    <= '0;
            misalign_o <= 1'b0;
            timeout_o  <= 1'b0;
            address    <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            writedata  <= '0;
            byteenable <= '0;
            cnt        <= '0;
            size_q     <= '0;
            signed_q   <= 1'b0;
            ofs_q      <= '0;
        end else begin
            busy_o <= state_n != IDLE;
            done_o <= state_n == RESP;
            if (state == IDLE && req_i) begin
                misalign_o <= mis;
                timeout_o  <= 1'b0;
                size_q     <= req_size_i;
                signed_q   <= req_signed_i;
                ofs_q      <= ofs;
                cnt        <= '0;
                if (!mis) begin
                    address    <= {req_addr_i[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
                    writedata  <= wdn;
                    byteenable <= ben;
                    read       <= !req_we_i;
                    write      <= req_we_i;
                end
            end
            if (state == ACCESS) begin
                if (waitrequest && cnt != '1) cnt <= cnt + 1'b1;
                if (state_n == RESP) begin
                    read      <= 1'b0;
                    write     <= 1'b0;
                    timeout_o <= tmo;
                    if (!waitrequest && read) rdata_o <= ext;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vector table plus multi-cycle sequences for
// stalls, misalignment, timeout and asynchronous reset.
module tb_mem_access_unit;
    logic        clk = 1'b0, reset_i = 1'b1;
    logic        req_i = 1'b0, req_we_i = 1'b0, req_signed_i = 1'b0, waitrequest = 1'b0;
    logic [1:0]  req_size_i = '0;
    logic [31:0] req_addr_i = '0, req_wdata_i = '0, readdata = '0;
    logic        busy_o, done_o, misalign_o, timeout_o, read, write;
    logic [31:0] rdata_o, address, writedata;
    logic [3:0]  byteenable;
    int          checks = 0, errors = 0;

    mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_WAIT(4)) dut (
        .clk(clk), .reset_i(reset_i), .req_i(req_i), .req_we_i(req_we_i),
        .req_size_i(req_size_i), .req_signed_i(req_signed_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o),
        .misalign_o(misalign_o), .timeout_o(timeout_o), .address(address), .read(read),
        .write(write), .waitrequest(waitrequest), .writedata(writedata),
        .byteenable(byteenable), .readdata(readdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  be;
        logic [31:0] wd, rd;
    } vec_t;
    vec_t tv[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata);
        @(negedge clk);
        req_we_i = we; req_size_i = size; req_signed_i = sgn;
        req_addr_i = addr; req_wdata_i = wdata; readdata = rdata; req_i = 1'b1;
        @(negedge clk);
        req_i = 1'b0;
        req_addr_i = 32'hFFFF_FFFF; req_wdata_i = 32'hFFFF_FFFF; req_size_i = 2'd0;
    endtask

    initial begin
        tv[0]  = '{1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 32'hDEADBEEF, 4'hF, 32'h0, 32'hDEADBEEF};
        tv[1]  = '{1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 32'h80112233, 4'h8, 32'h0, 32'hFFFFFF80};
        tv[2]  = '{1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 32'h80112233, 4'h8, 32'h0, 32'h00000080};
        tv[3]  = '{1'b0, 2'd1, 1'b1, 32'h1002, 32'h0, 32'h80112233, 4'hC, 32'h0, 32'hFFFF8011};
        tv[4]  = '{1'b0, 2'd1, 1'b0, 32'h1000, 32'h0, 32'h80118233, 4'h3, 32'h0, 32'h00008233};
        tv[5]  = '{1'b0, 2'd1, 1'b1, 32'h1000, 32'h0, 32'h80118233, 4'h3, 32'h0, 32'hFFFF8233};
        tv[6]  = '{1'b0, 2'd0, 1'b1, 32'h1001, 32'h0, 32'h80112233, 4'h2, 32'h0, 32'h00000022};
        tv[7]  = '{1'b0, 2'd2, 1'b1, 32'h1004, 32'h0, 32'h80000001, 4'hF, 32'h0, 32'h80000001};
        tv[8]  = '{1'b1, 2'd0, 1'b0, 32'h3001, 32'h123456AB, 32'h55555555, 4'h2, 32'h0000AB00, 32'h80000001};
        tv[9]  = '{1'b1, 2'd1, 1'b0, 32'h3002, 32'hFFFF1234, 32'h55555555, 4'hC, 32'h12340000, 32'h80000001};
        tv[10] = '{1'b1, 2'd2, 1'b0, 32'h3004, 32'hCAFEF00D, 32'h55555555, 4'hF, 32'hCAFEF00D, 32'h80000001};
        tv[11] = '{1'b1, 2'd0, 1'b0, 32'h3003, 32'h000000EE, 32'h55555555, 4'h8, 32'hEE000000, 32'h80000001};

        #1;
        chk("rst_busy", {31'b0, busy_o}, 0);
        chk("rst_done", {31'b0, done_o}, 0);
        chk("rst_strobe", {30'b0, read, write}, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_addr", address, 0);
        chk("rst_be", {28'b0, byteenable}, 0);
        chk("rst_wd", writedata, 0);
        chk("rst_flags", {30'b0, misalign_o, timeout_o}, 0);
        repeat (2) @(negedge clk);
        reset_i = 1'b0;

        for (int i = 0; i < 12; i++) begin
            issue(tv[i].we, tv[i].size, tv[i].sgn, tv[i].addr, tv[i].wdata, tv[i].rdata);
            chk($sformatf("v%0d_read", i), {31'b0, read}, {31'b0, !tv[i].we});
            chk($sformatf("v%0d_write", i), {31'b0, write}, {31'b0, tv[i].we});
            chk($sformatf("v%0d_addr", i), address, tv[i].addr & ~32'h3);
            chk($sformatf("v%0d_be", i), {28'b0, byteenable}, {28'b0, tv[i].be});
            chk($sformatf("v%0d_busy", i), {31'b0, busy_o}, 1);
            if (tv[i].we) chk($sformatf("v%0d_wd", i), writedata, tv[i].wd);
            @(negedge clk);
            chk($sformatf("v%0d_done", i), {31'b0, done_o}, 1);
            chk($sformatf("v%0d_rdata", i), rdata_o, tv[i].rd);
            chk($sformatf("v%0d_drop", i), {30'b0, read, write}, 0);
            chk($sformatf("v%0d_flags", i), {30'b0, misalign_o, timeout_o}, 0);
            @(negedge clk);
            chk($sformatf("v%0d_pulse", i), {31'b0, done_o}, 0);
            chk($sformatf("v%0d_idle", i), {31'b0, busy_o}, 0);
        end

        // SH with three waitrequest cycles; completion coincides with counter at MAX_WAIT-1
        waitrequest = 1'b1;
        issue(1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000ABCD, 32'h0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("sh_write%0d", k), {31'b0, write}, 1);
            chk($sformatf("sh_addr%0d", k), address, 32'h2000);
            chk($sformatf("sh_be%0d", k), {28'b0, byteenable}, 32'hC);
            chk($sformatf("sh_wd%0d", k), writedata, 32'hABCD0000);
            chk($sformatf("sh_done%0d", k), {31'b0, done_o}, 0);
            if (k == 3) waitrequest = 1'b0;
            @(negedge clk);
        end
        chk("sh_done", {31'b0, done_o}, 1);
        chk("sh_write_drop", {31'b0, write}, 0);
        chk("sh_no_timeout", {31'b0, timeout_o}, 0);

        issue(1'b0, 2'd2, 1'b0, 32'h1002, 32'h0, 32'h12345678);
        chk("mis_done", {31'b0, done_o}, 1);
        chk("mis_flag", {31'b0, misalign_o}, 1);
        chk("mis_strobe", {30'b0, read, write}, 0);
        chk("mis_rdata", rdata_o, 32'h80000001);
        @(negedge clk);
        chk("mis_pulse", {31'b0, done_o}, 0);
        chk("mis_hold", {31'b0, misalign_o}, 1);
        issue(1'b0, 2'd3, 1'b0, 32'h1000, 32'h0, 32'h0);
        chk("dword32_mis", {31'b0, misalign_o}, 1);
        chk("dword32_strobe", {30'b0, read, write}, 0);
        issue(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 32'h0BADF00D);
        chk("mis_clear", {31'b0, misalign_o}, 0);
        chk("clr_read", {31'b0, read}, 1);
        @(negedge clk);
        chk("clr_rdata", rdata_o, 32'h0BADF00D);

        waitrequest = 1'b1;
        begin
            int n = 0;
            issue(1'b0, 2'd2, 1'b0, 32'h1008, 32'h0, 32'h11111111);
            for (int k = 0; k < 20 && !done_o; k++) begin
                if (read) n++;
                @(negedge clk);
            end
            chk("to_done", {31'b0, done_o}, 1);
            chk("to_reads", n, 4);
            chk("to_flag", {31'b0, timeout_o}, 1);
            chk("to_read_drop", {31'b0, read}, 0);
            chk("to_rdata", rdata_o, 32'h0BADF00D);
        end
        waitrequest = 1'b0;
        @(negedge clk);
        chk("to_hold", {31'b0, timeout_o}, 1);
        issue(1'b0, 2'd0, 1'b0, 32'h1005, 32'h0, 32'h0000AB00);
        chk("to_clear", {31'b0, timeout_o}, 0);
        @(negedge clk);
        chk("lbu_rdata", rdata_o, 32'h000000AB);

        waitrequest = 1'b1;
        issue(1'b1, 2'd2, 1'b0, 32'h4000, 32'h01020304, 32'h0);
        chk("rst_pre_write", {31'b0, write}, 1);
        #2 reset_i = 1'b1;
        #1;
        chk("arst_write", {31'b0, write}, 0);
        chk("arst_busy", {31'b0, busy_o}, 0);
        chk("arst_done", {31'b0, done_o}, 0);
        @(negedge clk);
        reset_i = 1'b0;
        waitrequest = 1'b0;
        @(negedge clk);
        chk("arst_nodone", {31'b0, done_o}, 0);
        issue(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 32'hDEADBEEF);
        chk("fresh_read", {31'b0, read}, 1);
        @(negedge clk);
        chk("fresh_done", {31'b0, done_o}, 1);
        chk("fresh_rdata", rdata_o, 32'hDEADBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Parametrised Avalon-MM master sitting between the multicycle MIPS core's control/datapath and the memory bus. It accepts one load/store request at a time and handles waitrequest stalls. It generates byteenable and lane-shifted writedata for byte, halfword and word (and doubleword at DATA_WIDTH=64) accesses, and sign- or zero-extends sub-word read data. It also flags misaligned accesses and bus timeouts; the core stalls its FSM while busy_o is high.

Parameters:
ADDR_WIDTH, 32, byte-address width on both interfaces.
DATA_WIDTH, 32, bus and request data width; legal values 32 or 64. BYTES = DATA_WIDTH/8, OFS = log2(BYTES).
MAX_WAIT, 255, number of consecutive waitrequest-high cycles before timeout; 0 disables the timeout.

Ports:
clk  in  1  clock
reset_i  in  1  asynchronous active-high reset
req_i  in  1  request strobe, sampled in IDLE only
req_we_i  in  1  1=store, 0=load
req_size_i  in  2  access size: 0=byte, 1=half, 2=word, 3=dword (legal only when DATA_WIDTH=64)
req_signed_i  in  1  sign-extend load result (LB/LH vs LBU/LHU)
req_addr_i  in  ADDR_WIDTH  byte address
req_wdata_i  in  DATA_WIDTH  store data, right-aligned
busy_o  out  1  high whenever state != IDLE
done_o  out  1  one-cycle completion pulse
rdata_o  out  DATA_WIDTH  extended load result
misalign_o  out  1  error flag, valid with done_o
timeout_o  out  1  error flag, valid with done_o
address  out  ADDR_WIDTH  Avalon address, low OFS bits forced to 0
read  out  1  Avalon read
write  out  1  Avalon write
waitrequest  in  1  Avalon waitrequest
writedata  out  DATA_WIDTH  Avalon write data
byteenable  out  BYTES  Avalon byte enables
readdata  in  DATA_WIDTH  Avalon read data

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset_i` is asynchronous, active-high. On reset: state=IDLE; all outputs 0 (busy_o, done_o, rdata_o, misalign_o, timeout_o, address, read, write, writedata, byteenable); wait counter 0.
- All outputs are registered. No combinational path from waitrequest or readdata to any output.
- States:
  - IDLE → ACCESS on req_i when aligned. Alignment rule: addr[size-1:0]==0 (byte always aligned). Illegal size 3 with DATA_WIDTH=32 is treated as misaligned.
  - IDLE → RESP on req_i when misaligned: no bus cycle; misalign_o=1.
  - ACCESS: read/write asserted. address, writedata and byteenable are held stable while waitrequest=1.
  - ACCESS, waitrequest=0 → RESP: drop strobe; on a read, latch the extended result into rdata_o.
  - ACCESS, wait counter reaches MAX_WAIT (MAX_WAIT>0) → RESP with timeout_o=1: strobe dropped, rdata_o unchanged.
  - RESP: done_o=1 for exactly one cycle, then → IDLE. misalign_o and timeout_o are valid in RESP and cleared on the next accepted request.
- Request latching: all req_* are latched on acceptance. The core may change them afterwards. req_i is ignored while busy_o=1; no queueing.
- Latency: request at cycle N gives strobe at N+1. With waitrequest low at N+1, done_o is at N+2. Each waitrequest-high cycle adds one cycle.
- Byte enables: base mask of 2^size ones, shifted left by ofs = addr[OFS-1:0].
  - Example, 32-bit: byte @ofs 2 → 0100; half @ofs 2 → 1100; word → 1111.
- writedata: low 2^size bytes of req_wdata_i shifted left by 8*ofs. Unused lanes are 0.
- Read data:
  - readdata is shifted right by 8*ofs and the low 2^size bytes are kept.
  - Extension: if req_signed_i, sign-extend from the top bit of the access; else zero-extend.
  - Full-width access: passed through unchanged, req_signed_i ignored.
- Wait counter: clears on entering ACCESS; increments on each ACCESS cycle with waitrequest=1; saturates. Width is ceil(log2(MAX_WAIT+1)), minimum 1.
- Simultaneous events: if waitrequest falls in the same cycle the counter reaches MAX_WAIT, completion wins and timeout_o=0.
- Reset mid-ACCESS: strobes drop immediately (asynchronous). No done_o is issued for the aborted request.

Test Plan:
- Word load @0x1000, waitrequest=0, readdata=0xDEADBEEF → read=1 with address=0x1000 and byteenable=1111 at N+1; done_o at N+2; rdata_o=0xDEADBEEF.
- LB signed @0x1003, readdata=0x80112233 → byteenable=1000, rdata_o=0xFFFFFF80. Same access as LBU → 0x00000080.
- SH @0x2002, wdata=0x0000ABCD, waitrequest high for 3 cycles → write=1 held 4 cycles with address=0x2000, byteenable=1100, writedata=0xABCD0000 stable throughout; done_o 1 cycle after waitrequest falls.
- LW @0x1002 → no read/write asserted; done_o and misalign_o at N+1. Next aligned request clears misalign_o.
- MAX_WAIT=4, waitrequest stuck high → read drops after 4 wait cycles; done_o with timeout_o=1; rdata_o unchanged.
- reset_i pulsed while write=1 → write, busy_o and done_o go 0 asynchronously; state=IDLE; a fresh request then completes normally.
